// File: rtl/neuron_writeback.sv
// Write-back stage between the MAC core and the neuron RAM write port: rescales,
// rectifies and saturates each finished sum, buffers it, then commits it to RAM.
`timescale 1ns/1ps

module neuron_writeback #(
  parameter int ACC_W = 16,
  parameter int SHIFT = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       write_base,
  input  logic [7:0]       num_neurons,
  input  logic             acc_valid,
  input  logic [ACC_W-1:0] acc_data,
  output logic             acc_ready,
  input  logic             hold,
  output logic [7:0]       wr_addr,
  output logic [7:0]       wr_data,
  output logic             wre,
  output logic             busy,
  output logic             done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [7:0]    base_q;
  logic [7:0]    num_q;
  logic [7:0]    accepted;
  logic [7:0]    written;

  logic [7:0]    fifo_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] occupancy;
  logic          fifo_full;
  logic          fifo_empty;

  logic          push;
  logic          pop;
  logic signed [ACC_W-1:0] shifted;
  logic [7:0]    act_value;

  assign fifo_full  = (occupancy == CW'(DEPTH));
  assign fifo_empty = (occupancy == '0);

  // Activation: arithmetic rescale, then clamp into 0..127 before the value is queued.
  always_comb begin
    shifted   = $signed(acc_data) >>> SHIFT;
    act_value = 8'd0;
    if (shifted[ACC_W-1]) begin
      act_value = 8'd0;
    end else if (shifted > SAT_MAX) begin
      act_value = 8'd127;
    end else begin
      act_value = shifted[7:0];
    end
  end

  assign push = acc_valid && acc_ready;
  assign pop  = ((state == RUN) || (state == DRAIN)) && !fifo_empty && !hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A zero-length layer skips straight to DONE; DRAIN waits until the final write has been issued.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (num_neurons == 8'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (push && ((accepted + 8'd1) == num_q)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (written == num_q) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Ready is derived from registered state only, so a pop in the same cycle never reopens a full FIFO.
  always_comb begin
    acc_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      RUN: begin
        acc_ready = !fifo_full && (accepted < num_q);
        busy      = 1'b1;
      end
      DRAIN: begin
        busy = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        acc_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q   <= 8'd0;
      num_q    <= 8'd0;
      accepted <= 8'd0;
      written  <= 8'd0;
    end else if ((state == IDLE) && start) begin
      base_q   <= write_base;
      num_q    <= num_neurons;
      accepted <= 8'd0;
      written  <= 8'd0;
    end else begin
      if (push) begin
        accepted <= accepted + 8'd1;
      end
      if (pop) begin
        written <= written + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= act_value;
    end
  end

  // Address and data are only updated on an actual write, so they hold between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wre     <= 1'b0;
      wr_addr <= 8'd0;
      wr_data <= 8'd0;
    end else begin
      wre <= pop;
      if (pop) begin
        wr_addr <= base_q + written;
        wr_data <= fifo_mem[rd_ptr];
      end
    end
  end

endmodule
